// File: rtl/clkgen_param.sv
// ---------------------------------------------------------------------------
// clkgen_param
//   Parametrised divided-clock generator. A single down counter running on
//   clk8f produces NUM_DIV phase-aligned divided clocks (bit i has a period
//   of 2^(i+1) clk8f cycles). It also produces single-cycle rise/fall enables
//   per rate, a frame strobe when all clocks rise together, and a lock flag
//   once LOCK_FRAMES frames have completed.
//
// Parameters
//   NUM_DIV      number of divided outputs (>= 1)
//   LOCK_FRAMES  completed frames before locked asserts (>= 1)
//
// Ports
//   clk8f      in   fundamental clock, all logic on posedge
//   reset      in   asynchronous active-high reset
//   enable     in   1: counter advances each cycle, 0: state held, strobes 0
//   sync_clr   in   synchronous clear / phase realign, wins over enable
//   clk_div    out  divided clocks, bit 0 = clk8f/2 (equal to the counter)
//   rise_stb   out  pulse in the first cycle where clk_div[i] is 1
//   fall_stb   out  pulse in the first cycle where clk_div[i] is 0
//   frame_stb  out  pulse when the counter wraps 0 -> all-ones
//   locked     out  1 once LOCK_FRAMES frame strobes seen since clear
// ---------------------------------------------------------------------------
module clkgen_param #(
  parameter int NUM_DIV     = 3,
  parameter int LOCK_FRAMES = 1
) (
  input  logic               clk8f,
  input  logic               reset,
  input  logic               enable,
  input  logic               sync_clr,
  output logic [NUM_DIV-1:0] clk_div,
  output logic [NUM_DIV-1:0] rise_stb,
  output logic [NUM_DIV-1:0] fall_stb,
  output logic               frame_stb,
  output logic               locked
);

  localparam int             FW       = $clog2(LOCK_FRAMES + 1);
  localparam logic [FW-1:0]  LOCK_MAX = FW'(LOCK_FRAMES);

  logic [NUM_DIV-1:0] cnt;
  logic [NUM_DIV-1:0] cnt_next;
  logic [FW-1:0]      frame_cnt;
  logic               wrap;

  assign cnt_next = cnt - NUM_DIV'(1);
  // Counting down from zero is the one step where every bit goes 0 -> 1,
  // i.e. every divided clock rises in the same cycle.
  assign wrap     = (cnt == '0);

  // Clock outputs come straight from flops: no glitches from decode logic.
  assign clk_div  = cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of cnt; blocking here would chain the updates.
  always_ff @(posedge clk8f or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      rise_stb  <= '0;
      fall_stb  <= '0;
      frame_stb <= 1'b0;
      frame_cnt <= '0;
      locked    <= 1'b0;
    end else if (sync_clr) begin
      cnt       <= '0;
      rise_stb  <= '0;
      fall_stb  <= '0;
      frame_stb <= 1'b0;
      frame_cnt <= '0;
      locked    <= 1'b0;
    end else if (enable) begin
      cnt       <= cnt_next;
      // Strobes are registered alongside the new count so they line up with
      // the first cycle in which the divided clock shows its new level.
      rise_stb  <= cnt_next & ~cnt;
      fall_stb  <= ~cnt_next & cnt;
      frame_stb <= wrap;
      if (wrap && (frame_cnt != LOCK_MAX)) begin
        frame_cnt <= frame_cnt + FW'(1);
      end
      if (wrap && (frame_cnt == LOCK_MAX - FW'(1))) begin
        locked <= 1'b1;
      end
    end else begin
      // Frozen: count and lock state hold, but no stale pulses are repeated.
      rise_stb  <= '0;
      fall_stb  <= '0;
      frame_stb <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clkgen_param.sv
// ---------------------------------------------------------------------------
// tb_clkgen_param
//   Self-checking bench for clkgen_param. Two instances share the stimulus:
//   u_dut3 (NUM_DIV=3, LOCK_FRAMES=2) and u_dut5 (NUM_DIV=5, LOCK_FRAMES=1).
//   The reference model tracks only the number of enabled edges since the
//   last clear; every expected output is derived from that number with
//   modular arithmetic.
// ---------------------------------------------------------------------------
module tb_clkgen_param;

  logic       clk8f = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       sync_clr = 1'b0;

  logic [2:0] div3, rise3, fall3;
  logic       frame3, lock3;
  logic [4:0] div5, rise5, fall5;
  logic       frame5, lock5;

  int tests = 0;
  int failed = 0;

  // Model state: enabled edges since last clear, and whether the most recent
  // edge was an advancing one (strobes are only live after such an edge).
  int n_steps = 0;
  bit valid   = 1'b0;

  always #5 clk8f = ~clk8f;

  clkgen_param #(.NUM_DIV(3), .LOCK_FRAMES(2)) u_dut3 (
    .clk8f(clk8f), .reset(reset), .enable(enable), .sync_clr(sync_clr),
    .clk_div(div3), .rise_stb(rise3), .fall_stb(fall3),
    .frame_stb(frame3), .locked(lock3)
  );

  clkgen_param #(.NUM_DIV(5), .LOCK_FRAMES(1)) u_dut5 (
    .clk8f(clk8f), .reset(reset), .enable(enable), .sync_clr(sync_clr),
    .clk_div(div5), .rise_stb(rise5), .fall_stb(fall5),
    .frame_stb(frame5), .locked(lock5)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Counter value after n down-steps from zero, modulo 2^nd.
  function automatic int exp_cnt(input int n, input int nd);
    int m = 1 << nd;
    return (m - (n % m)) % m;
  endfunction

  function automatic int exp_rise(input int n, input int nd, input bit v);
    if (!v || n < 1) return 0;
    return exp_cnt(n, nd) & ~exp_cnt(n - 1, nd) & ((1 << nd) - 1);
  endfunction

  function automatic int exp_fall(input int n, input int nd, input bit v);
    if (!v || n < 1) return 0;
    return ~exp_cnt(n, nd) & exp_cnt(n - 1, nd) & ((1 << nd) - 1);
  endfunction

  function automatic int exp_frame(input int n, input int nd, input bit v);
    if (!v || n < 1) return 0;
    return (((n - 1) % (1 << nd)) == 0) ? 1 : 0;
  endfunction

  // Frames completed = number of wraps among steps 0..n-1 = ceil(n / 2^nd).
  function automatic int exp_locked(input int n, input int nd, input int lf);
    int m = 1 << nd;
    return (((n + m - 1) / m) >= lf) ? 1 : 0;
  endfunction

  // Model update, same priority as the hardware contract.
  always @(posedge clk8f or posedge reset) begin
    if (reset) begin
      n_steps = 0;
      valid   = 1'b0;
    end else if (sync_clr) begin
      n_steps = 0;
      valid   = 1'b0;
    end else if (enable) begin
      n_steps = n_steps + 1;
      valid   = 1'b1;
    end else begin
      valid   = 1'b0;
    end
  end

  // Compare process: every falling edge, both instances against the model.
  always @(negedge clk8f) begin
    check("d3_clk_div",   int'(div3),   exp_cnt(n_steps, 3));
    check("d3_rise_stb",  int'(rise3),  exp_rise(n_steps, 3, valid));
    check("d3_fall_stb",  int'(fall3),  exp_fall(n_steps, 3, valid));
    check("d3_frame_stb", int'(frame3), exp_frame(n_steps, 3, valid));
    check("d3_locked",    int'(lock3),  exp_locked(n_steps, 3, 2));
    check("d5_clk_div",   int'(div5),   exp_cnt(n_steps, 5));
    check("d5_rise_stb",  int'(rise5),  exp_rise(n_steps, 5, valid));
    check("d5_fall_stb",  int'(fall5),  exp_fall(n_steps, 5, valid));
    check("d5_frame_stb", int'(frame5), exp_frame(n_steps, 5, valid));
    check("d5_locked",    int'(lock5),  exp_locked(n_steps, 5, 1));
  end

  // One clock edge with the given controls; returns 1 ns after the edge.
  task automatic step(input bit en, input bit clr);
    enable   = en;
    sync_clr = clr;
    @(posedge clk8f);
    #1;
  endtask

  // Assert reset between edges and confirm outputs drop without a clock.
  task automatic async_reset_pulse();
    #2 reset = 1'b1;
    #1;
    check("async_rst_div3",   int'(div3),   0);
    check("async_rst_lock3",  int'(lock3),  0);
    check("async_rst_rise5",  int'(rise5),  0);
    check("async_rst_frame5", int'(frame5), 0);
    @(negedge clk8f);
    #2 reset = 1'b0;
  endtask

  int seq3 [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
  int frames5;
  int high2;

  initial begin
    // Reset state
    repeat (2) @(posedge clk8f);
    #1;
    check("reset_div3",  int'(div3),  0);
    check("reset_lock3", int'(lock3), 0);
    check("reset_div5",  int'(div5),  0);
    reset = 1'b0;

    // Free-running count from reset: literal sequence and strobes
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b0);
      check("seq_div3", int'(div3), seq3[i]);
      if (i == 0) begin
        check("c1_rise3",  int'(rise3),  7);
        check("c1_frame3", int'(frame3), 1);
        check("c1_lock3",  int'(lock3),  0);
        check("c1_div5",   int'(div5),   31);
        check("c1_lock5",  int'(lock5),  1);
      end
      if (i == 1) check("c2_fall3", int'(fall3), 1);
      if (i == 2) check("c3_fall3", int'(fall3), 2);
      if (i == 4) check("c5_fall3", int'(fall3), 4);
      if (i == 8) begin
        check("c9_rise3",  int'(rise3),  7);
        check("c9_frame3", int'(frame3), 1);
        check("c9_lock3",  int'(lock3),  1);
      end
    end

    // Freeze at cnt=101 for five cycles, then resume
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("pre_hold_div3", int'(div3), 5);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      check("hold_div3",  int'(div3),  5);
      check("hold_rise3", int'(rise3), 0);
      check("hold_fall3", int'(fall3), 0);
    end
    step(1'b1, 1'b0);
    check("resume_div3", int'(div3), 4);

    // Sync clear at cnt=010
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("pre_clr_div3", int'(div3), 2);
    step(1'b1, 1'b1);
    check("clr_div3",  int'(div3),  0);
    check("clr_lock3", int'(lock3), 0);
    step(1'b1, 1'b0);
    check("post_clr_div3",   int'(div3),   7);
    check("post_clr_frame3", int'(frame3), 1);

    // 64 free-running cycles: /32 frame rate and 50% duty on the /8 output
    frames5 = 0;
    high2   = 0;
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 1'b0);
      if (frame5) begin
        frames5++;
        check("frame5_rise4", int'(rise5[4]), 1);
      end
      if (div3[2]) high2++;
    end
    check("frames5_in_64", frames5, 2);
    check("duty_div3_2",   high2,   32);

    // Reset mid-cycle once locked
    check("lock3_before_rst", int'(lock3), 1);
    async_reset_pulse();
    @(posedge clk8f);
    #1;

    // Randomised run with occasional clears and asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 99) < 2));
      if ($urandom_range(0, 199) == 0) begin
        async_reset_pulse();
        @(posedge clk8f);
        #1;
      end
    end

    enable   = 1'b0;
    sync_clr = 1'b0;
    @(negedge clk8f);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
